// File: rtl/pixel_stream_pkg.sv
// Shared types and sizing helpers for the pixel stream adapter.
// Default parameter values mirror the correlation-matrix stage configuration.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } psa_state_t;

    function automatic int unsigned words_per_frame(input int unsigned total,
                                                    input int unsigned pack);
        return (total + pack - 1) / pack;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned PSA_N          = 11;
    localparam int unsigned PSA_M          = 5;
    localparam int unsigned PSA_WIDTH      = 32;
    localparam int unsigned PSA_PACK       = 2;
    localparam int unsigned PSA_FIFO_DEPTH = 8;
    localparam int unsigned PSA_TOTAL      = PSA_N * PSA_M;
    localparam int unsigned PSA_WORDS      = words_per_frame(PSA_TOTAL, PSA_PACK);
    localparam int unsigned PSA_TOTAL_W    = cnt_width(PSA_TOTAL);
    localparam int unsigned PSA_WORDS_W    = cnt_width(PSA_WORDS);

endpackage

// File: rtl/pixel_stream_adapter_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module sync_fifo
    import pixel_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pixel_stream_adapter.sv
// Unpacks PACK-scalar input words into a scalar stream, one N*M frame per start.
// Optional starvation counter enabled by defining PSA_STALL_COUNT_EN.
module pixel_stream_adapter
    import pixel_stream_pkg::*;
#(
    parameter int unsigned N          = PSA_N,
    parameter int unsigned M          = PSA_M,
    parameter int unsigned WIDTH      = PSA_WIDTH,
    parameter int unsigned PACK       = PSA_PACK,
    parameter int unsigned FIFO_DEPTH = PSA_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic [PACK*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ds_next_data,
    output logic [WIDTH-1:0]      ds_out,
    output logic                  ds_valid
`ifdef PSA_STALL_COUNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned TOTAL = N * M;
    localparam int unsigned WORDS = words_per_frame(TOTAL, PACK);
    localparam int unsigned TW    = cnt_width(TOTAL);
    localparam int unsigned WW    = cnt_width(WORDS);
    localparam int unsigned LW    = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [TW-1:0] TOTAL_C   = TW'(TOTAL);
    localparam logic [TW-1:0] LAST_C    = TW'(TOTAL - 1);
    localparam logic [WW-1:0] WORDS_C   = WW'(WORDS);
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

    psa_state_t             state_q, state_d;
    logic [WW-1:0]          word_cnt_q, word_cnt_d;
    logic [TW-1:0]          push_cnt_q, push_cnt_d;
    logic [TW-1:0]          out_cnt_q, out_cnt_d;
    logic                   up_full_q, up_full_d;
    logic [PACK*WIDTH-1:0]  up_word_q, up_word_d;
    logic [LW-1:0]          up_lane_q, up_lane_d;

    logic                   start_accept, push_now, up_emptying, word_accept, pop;
    logic                   fifo_full, fifo_empty;
    logic [WIDTH-1:0]       fifo_din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (pop && (out_cnt_q == LAST_C)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == STREAM);
        frame_done = (state_q == DONE);
    end

    // The register may refill in the same cycle its last lane is pushed, so
    // in_ready looks ahead at the emptying condition.
    always_comb begin
        start_accept = (state_q == IDLE) && start;
        push_now     = up_full_q && !fifo_full && (push_cnt_q < TOTAL_C);
        up_emptying  = push_now && ((up_lane_q == LAST_LANE) || (push_cnt_q == LAST_C));
        in_ready     = (state_q == STREAM) && (word_cnt_q < WORDS_C)
                       && (!up_full_q || up_emptying);
        word_accept  = in_valid && in_ready;
        ds_valid     = !fifo_empty;
        pop          = ds_valid && ds_next_data;
        fifo_din     = up_word_q[WIDTH*int'(up_lane_q) +: WIDTH];
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        push_cnt_d = push_cnt_q;
        out_cnt_d  = out_cnt_q;
        up_full_d  = up_full_q;
        up_word_d  = up_word_q;
        up_lane_d  = up_lane_q;
        if (start_accept) begin
            word_cnt_d = '0;
            push_cnt_d = '0;
            out_cnt_d  = '0;
            up_full_d  = 1'b0;
            up_lane_d  = '0;
        end else begin
            if (push_now) begin
                push_cnt_d = push_cnt_q + 1'b1;
                if (up_emptying) begin
                    up_full_d = 1'b0;
                end else begin
                    up_lane_d = up_lane_q + 1'b1;
                end
            end
            if (word_accept) begin
                word_cnt_d = word_cnt_q + 1'b1;
                up_full_d  = 1'b1;
                up_word_d  = in_data;
                up_lane_d  = '0;
            end
            if (pop) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q <= '0;
            push_cnt_q <= '0;
            out_cnt_q  <= '0;
            up_full_q  <= 1'b0;
            up_word_q  <= '0;
            up_lane_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            push_cnt_q <= push_cnt_d;
            out_cnt_q  <= out_cnt_d;
            up_full_q  <= up_full_d;
            up_word_q  <= up_word_d;
            up_lane_q  <= up_lane_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_now),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (ds_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef PSA_STALL_COUNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_accept) begin
            stall_d = '0;
        end else if ((state_q == STREAM) && ds_next_data && !ds_valid && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pixel_stream_adapter.sv
// Scoreboard bench for pixel_stream_adapter; stall counter tests run when
// PSA_STALL_COUNT_EN is defined.
module tb_pixel_stream_adapter;

    localparam int unsigned N          = 11;
    localparam int unsigned M          = 5;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned PACK       = 2;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned TOTAL      = N * M;
    localparam int unsigned WORDS      = (TOTAL + PACK - 1) / PACK;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  frame_done;
    logic [PACK*WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  ds_next_data;
    logic [WIDTH-1:0]      ds_out;
    logic                  ds_valid;
`ifdef PSA_STALL_COUNT_EN
    logic [31:0]           stall_cycles;
`endif

    pixel_stream_adapter #(
        .N          (N),
        .M          (M),
        .WIDTH      (WIDTH),
        .PACK       (PACK),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ds_next_data (ds_next_data),
        .ds_out       (ds_out),
        .ds_valid     (ds_valid)
`ifdef PSA_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus modes: vmode 0=always,1=one-in-three,2=random,3=held low;
    // rmode 0=always ready,1=random,2=held low.
    int vmode = 0;
    int rmode = 0;

    logic [PACK*WIDTH-1:0] words_arr [WORDS];
    logic [WIDTH-1:0]      exp_q [$];
    int                    words_in   = WORDS;
    int                    out_count  = 0;
    int                    fd_count   = 0;
    int                    first_acc  = -1;
    int                    first_val  = -1;
    int                    last_pop   = -1;
    int                    gap_cycles = 0;
    logic [WIDTH-1:0]      first_pop  = '0;
    bit                    frame_active = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic build_words(input bit pattern);
        for (int w = 0; w < int'(WORDS); w++) begin
            for (int j = 0; j < int'(PACK); j++) begin
                logic [WIDTH-1:0] lane;
                lane = pattern ? WIDTH'(w * PACK + j) : WIDTH'($urandom);
                words_arr[w][j*WIDTH +: WIDTH] = lane;
            end
        end
    endtask

    // Input driver: applies modes a little after each rising edge.
    always begin
        @(posedge clk);
        #1;
        case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 3 == 0);
            2:       in_valid = ($urandom_range(0, 3) != 0);
            default: in_valid = 1'b0;
        endcase
        if (words_in < int'(WORDS)) in_data = words_arr[words_in];
        else in_data = {$urandom, $urandom};
        case (rmode)
            0:       ds_next_data = 1'b1;
            1:       ds_next_data = ($urandom_range(0, 2) != 0);
            default: ds_next_data = 1'b0;
        endcase
    end

    // Input monitor: every accepted word feeds the reference stream.
    always @(negedge clk) begin
        if (rst && frame_active && in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            for (int j = 0; j < int'(PACK); j++) begin
                if (words_in * int'(PACK) + j < int'(TOTAL))
                    exp_q.push_back(in_data[j*WIDTH +: WIDTH]);
            end
            words_in++;
        end
    end

    // Output monitor: compares each transfer with the reference stream.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_active && ds_valid && first_val < 0) first_val = cyc;
            if (frame_active && first_val >= 0 && !ds_valid && out_count < int'(TOTAL))
                gap_cycles++;
            if (!ds_valid) check("ds_out_zero_when_empty", ds_out, 0);
            if (ds_valid && ds_next_data) begin
                check("pop_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("ds_out", ds_out, exp_q.pop_front());
                if (out_count == 0) first_pop = ds_out;
                out_count++;
                last_pop = cyc;
            end
            if (frame_done) begin
                fd_count++;
                check("frame_done_after_last", cyc, last_pop + 1);
                check("frame_done_count_out", out_count, TOTAL);
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic begin_frame(input bit pattern);
        @(posedge clk);
        build_words(pattern);
        exp_q.delete();
        words_in   = 0;
        out_count  = 0;
        fd_count   = 0;
        first_acc  = -1;
        first_val  = -1;
        last_pop   = -1;
        gap_cycles = 0;
        frame_active = 1'b1;
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic end_frame(input bit full_rate);
        int budget;
        budget = 0;
        while (fd_count == 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        check("frame_done_seen", fd_count != 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("frame_done_once", fd_count, 1);
        check("words_accepted", words_in, WORDS);
        check("scalars_out", out_count, TOTAL);
        check("queue_drained", exp_q.size(), 0);
        check("fill_latency", first_val - first_acc, 2);
        check("idle_after_done", busy, 0);
        if (full_rate) check("full_rate_span", last_pop - first_val + 1, TOTAL);
        frame_active = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int budget;
        int sz;
        rst          = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b1;
        in_data      = '0;
        ds_next_data = 1'b1;
        build_words(1'b1);

        // Reset held with traffic and start pulses present.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 start = ~start;
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_ds_valid", ds_valid, 0);
            check("rst_ds_out", ds_out, 0);
        end
        @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", in_ready, 0);
        check("post_rst_ds_valid", ds_valid, 0);

        // Full-rate frame with the counting pattern.
        vmode = 0; rmode = 0;
        begin_frame(1'b1);
        end_frame(1'b1);
        check("full_rate_first_scalar", first_pop, 0);

        // Backpressure mid-frame.
        vmode = 0; rmode = 0;
        begin_frame(1'b1);
        repeat (12) @(posedge clk);
        rmode = 2;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        sz = exp_q.size();
        check("bp_ds_valid", ds_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_buffered", (sz >= int'(FIFO_DEPTH) + 1) && (sz <= int'(FIFO_DEPTH + PACK)), 1);
        if (sz != 0) check("bp_head", ds_out, exp_q[0]);
        @(posedge clk);
        rmode = 0;
        end_frame(1'b0);

        // Sparse input words.
        vmode = 1; rmode = 0;
        begin_frame(1'b1);
        end_frame(1'b0);
        check("gaps_seen", gap_cycles > 0, 1);

        // Random data, valid and ready.
        for (int f = 0; f < 3; f++) begin
            vmode = 2; rmode = 1;
            begin_frame(1'b0);
            end_frame(1'b0);
        end

        // Reset in the middle of a frame.
        vmode = 0; rmode = 0;
        begin_frame(1'b1);
        budget = 0;
        while (out_count < 10 && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        check("midrst_reached_10", out_count >= 10, 1);
        #1 rst = 1'b0;
        frame_active = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_ds_valid", ds_valid, 0);
        check("midrst_ds_out", ds_out, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        begin_frame(1'b1);
        end_frame(1'b1);
        check("midrst_restart_elem0", first_pop, 0);

`ifdef PSA_STALL_COUNT_EN
        // Consumer starved for 15 cycles plus the 2-cycle fill latency.
        vmode = 3; rmode = 0;
        begin_frame(1'b1);
        repeat (15) @(posedge clk);
        vmode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_after_fill", stall_cycles, 17);
        end_frame(1'b0);
        check("stall_held_after_done", stall_cycles, 17);
        vmode = 0;
        begin_frame(1'b1);
        check("stall_cleared_on_start", stall_cycles, 0);
        end_frame(1'b1);
        check("stall_full_rate", stall_cycles, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
